ram_dp_arbiter_ctrl: RTL and testbench

//  Synchronous sequencer/arbiter sharing one async dual-port RAM (DATA_WIDTH x RAM_DEPTH) between two clients.

---
 rtl/ram_dp_arbiter_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ram_dp_arbiter_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_arbiter_ctrl.sv
// Two-client req/gnt arbiter and strobe sequencer in front of an async dual-port RAM.
// Port 0 is used only for writes and port 1 only for reads; every output is registered.
module ram_dp_arbiter_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_c,
    input  logic [1:0]            we_c,
    input  logic [ADDR_WIDTH-1:0] addr_c0,
    input  logic [ADDR_WIDTH-1:0] addr_c1,
    input  logic [DATA_WIDTH-1:0] wdata_c0,
    input  logic [DATA_WIDTH-1:0] wdata_c1,
    output logic [1:0]            gnt_c,
    output logic [1:0]            rvalid_c,
    output logic [DATA_WIDTH-1:0] rdata_c0,
    output logic [DATA_WIDTH-1:0] rdata_c1,
    output logic [1:0]            err_c,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_address_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic                  ram_cs_0,
    output logic                  ram_we_0,
    output logic                  ram_oe_0,
    output logic [ADDR_WIDTH-1:0] ram_address_1,
    output logic                  ram_cs_1,
    output logic                  ram_we_1,
    output logic                  ram_oe_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_SETUP,
        R_CAP,
        ERR
    } state_t;

    // One extra bit so the limit itself is representable when RAM_DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = RAM_DEPTH[ADDR_WIDTH:0];

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  sel_q, sel_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            err_q, err_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic                  busy_q, busy_d;
    logic                  cs_0_q, cs_0_d;
    logic                  we_0_q, we_0_d;
    logic                  cs_1_q, cs_1_d;
    logic                  oe_1_q, oe_1_d;
    logic [ADDR_WIDTH-1:0] addr_0_q, addr_0_d;
    logic [DATA_WIDTH-1:0] data_0_q, data_0_d;
    logic [ADDR_WIDTH-1:0] addr_1_q, addr_1_d;
    logic [1:0]            cap_en;

    logic                  pick;
    logic                  pick_we;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        sel_d      = sel_q;
        gnt_d      = 2'b00;
        err_d      = 2'b00;
        rvalid_d   = 2'b00;
        cap_en     = 2'b00;
        cs_0_d     = 1'b0;
        we_0_d     = 1'b0;
        cs_1_d     = 1'b0;
        oe_1_d     = 1'b0;
        addr_0_d   = addr_0_q;
        data_0_d   = data_0_q;
        addr_1_d   = addr_1_q;

        // With both clients requesting, the one not served last time wins.
        if (req_c == 2'b11) begin
            pick = ~last_gnt_q;
        end else begin
            pick = req_c[1];
        end
        pick_we    = pick ? we_c[1]  : we_c[0];
        pick_addr  = pick ? addr_c1  : addr_c0;
        pick_wdata = pick ? wdata_c1 : wdata_c0;

        case (state_q)
            IDLE: begin
                if (req_c != 2'b00) begin
                    sel_d       = pick;
                    last_gnt_d  = pick;
                    gnt_d[pick] = 1'b1;
                    if ({1'b0, pick_addr} >= DEPTH_LIM) begin
                        state_d     = ERR;
                        err_d[pick] = 1'b1;
                    end else if (pick_we) begin
                        state_d  = W_SETUP;
                        cs_0_d   = 1'b1;
                        addr_0_d = pick_addr;
                        data_0_d = pick_wdata;
                    end else begin
                        state_d  = R_SETUP;
                        cs_1_d   = 1'b1;
                        oe_1_d   = 1'b1;
                        addr_1_d = pick_addr;
                    end
                end
            end
            W_SETUP: begin
                state_d = W_PULSE;
                cs_0_d  = 1'b1;
                we_0_d  = 1'b1;
            end
            W_PULSE: begin
                state_d = W_HOLD;
                cs_0_d  = 1'b1;
            end
            R_SETUP: begin
                state_d = R_CAP;
                cs_1_d  = 1'b1;
                oe_1_d  = 1'b1;
            end
            R_CAP: begin
                state_d         = IDLE;
                rvalid_d[sel_q] = 1'b1;
                cap_en[sel_q]   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            sel_q      <= 1'b0;
            gnt_q      <= 2'b00;
            err_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            busy_q     <= 1'b0;
            cs_0_q     <= 1'b0;
            we_0_q     <= 1'b0;
            cs_1_q     <= 1'b0;
            oe_1_q     <= 1'b0;
            addr_0_q   <= '0;
            data_0_q   <= '0;
            addr_1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            err_q      <= err_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
            cs_0_q     <= cs_0_d;
            we_0_q     <= we_0_d;
            cs_1_q     <= cs_1_d;
            oe_1_q     <= oe_1_d;
            addr_0_q   <= addr_0_d;
            data_0_q   <= data_0_d;
            addr_1_q   <= addr_1_d;
        end
    end

    // Per-client read-data holding registers, loaded only when that client's read completes.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = cap_en[gi] ? ram_data_1 : rdata_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign gnt_c         = gnt_q;
    assign err_c         = err_q;
    assign rvalid_c      = rvalid_q;
    assign busy          = busy_q;
    assign rdata_c0      = g_rdata[0].rdata_q;
    assign rdata_c1      = g_rdata[1].rdata_q;
    assign ram_address_0 = addr_0_q;
    assign ram_data_0    = data_0_q;
    assign ram_cs_0      = cs_0_q;
    assign ram_we_0      = we_0_q;
    assign ram_oe_0      = 1'b0;
    assign ram_address_1 = addr_1_q;
    assign ram_cs_1      = cs_1_q;
    assign ram_we_1      = 1'b0;
    assign ram_oe_1      = oe_1_q;

endmodule

// File: tb/tb_ram_dp_arbiter_ctrl.sv
// Bench for ram_dp_arbiter_ctrl: RAM model, transaction-level reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_ram_dp_arbiter_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;

    logic [1:0]    req_c, we_c;
    logic [1:0]    gnt_c, rvalid_c, err_c;
    logic [DW-1:0] rdata_c0, rdata_c1, ram_data_0, ram_data_1;
    logic [AW-1:0] ram_address_0, ram_address_1;
    logic          busy, ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_we_1, ram_oe_1;

    assign req_c = {req1, req0};
    assign we_c  = {we1, we0};

    always #5 clk = ~clk;

    ram_dp_arbiter_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_c(req_c), .we_c(we_c),
        .addr_c0(a0), .addr_c1(a1), .wdata_c0(wd0), .wdata_c1(wd1),
        .gnt_c(gnt_c), .rvalid_c(rvalid_c), .rdata_c0(rdata_c0), .rdata_c1(rdata_c1),
        .err_c(err_c), .busy(busy),
        .ram_address_0(ram_address_0), .ram_data_0(ram_data_0), .ram_cs_0(ram_cs_0),
        .ram_we_0(ram_we_0), .ram_oe_0(ram_oe_0),
        .ram_address_1(ram_address_1), .ram_cs_1(ram_cs_1), .ram_we_1(ram_we_1),
        .ram_oe_1(ram_oe_1), .ram_data_1(ram_data_1)
    );

    // Async RAM stand-in: writes land at the end of the we pulse, reads are combinational.
    logic [DW-1:0] ram [64];
    always @(posedge clk) if (ram_cs_0 && ram_we_0) ram[ram_address_0] <= ram_data_0;
    assign ram_data_1 = (ram_cs_1 && ram_oe_1) ? ram[ram_address_1] : '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation occupies m_len cycles counted from its selection edge
    // (write 4, read 3, error 2), the last of which is the idle cycle where the next pick happens.
    bit            m_act, m_cl, m_last;
    int            m_d, m_len, m_kind;   // kind: 0 write, 1 read, 2 error
    logic [AW-1:0] m_addr, m_a0, m_a1;
    logic [DW-1:0] m_wd, m_d0;
    logic [DW-1:0] m_rd [2];
    logic [DW-1:0] mmem [64];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_act = 0; m_d = 0; m_len = 0; m_kind = 0; m_cl = 0; m_last = 1;
                m_a0 = '0; m_a1 = '0; m_d0 = '0; m_rd[0] = '0; m_rd[1] = '0;
            end else if (m_act && m_d < m_len) begin
                m_d++;
                if (m_d == 3 && m_kind == 0) mmem[m_addr] = m_wd;
                if (m_d == 3 && m_kind == 1) m_rd[m_cl] = mmem[m_addr];
            end else begin
                m_act = 0;
                if (req0 || req1) begin
                    m_cl   = (req0 && req1) ? !m_last : req1;
                    m_last = m_cl;
                    m_act  = 1;
                    m_d    = 1;
                    m_addr = m_cl ? a1 : a0;
                    m_wd   = m_cl ? wd1 : wd0;
                    if (int'(m_addr) >= DEPTH) begin
                        m_kind = 2; m_len = 2;
                    end else if (m_cl ? we1 : we0) begin
                        m_kind = 0; m_len = 4; m_a0 = m_addr; m_d0 = m_wd;
                    end else begin
                        m_kind = 1; m_len = 3; m_a1 = m_addr;
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] oh;
        forever begin
            @(negedge clk);
            oh = m_cl ? 2'b10 : 2'b01;
            chk("m_gnt",    gnt_c,    (m_act && m_d == 1) ? oh : 2'b00);
            chk("m_err",    err_c,    (m_act && m_kind == 2 && m_d == 1) ? oh : 2'b00);
            chk("m_rvalid", rvalid_c, (m_act && m_kind == 1 && m_d == 3) ? oh : 2'b00);
            chk("m_busy",   busy,     m_act && m_d < m_len);
            chk("m_cs0",    ram_cs_0, m_act && m_kind == 0 && m_d <= 3);
            chk("m_we0",    ram_we_0, m_act && m_kind == 0 && m_d == 2);
            chk("m_cs1",    ram_cs_1, m_act && m_kind == 1 && m_d <= 2);
            chk("m_oe1",    ram_oe_1, m_act && m_kind == 1 && m_d <= 2);
            chk("m_ties",   {ram_oe_0, ram_we_1}, 2'b00);
            chk("m_addr0",  ram_address_0, m_a0);
            chk("m_data0",  ram_data_0,    m_d0);
            chk("m_addr1",  ram_address_1, m_a1);
            chk("m_rdata0", rdata_c0, m_rd[0]);
            chk("m_rdata1", rdata_c1, m_rd[1]);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int gq[$];

    task automatic client_run(input bit c);
        bit got;
        for (int i = 0; i < 4; i++) begin
            if (c == 1'b0) begin
                we0 = 1'b1; a0 = AW'(10 + i); wd0 = 32'h1111_0000 + i; req0 = 1'b1;
            end else begin
                we1 = 1'b0; a1 = AW'(10 + i); req1 = 1'b1;
            end
            got = 0;
            for (int n = 0; n < 60; n++) begin
                tick;
                if (gnt_c[c]) begin
                    got = 1;
                    break;
                end
            end
            chk("t3_gnt_timeout", got, 1'b1);
            gq.push_back(int'(c));
            if (c == 1'b0) req0 = 1'b0; else req1 = 1'b0;
            tick;
        end
    endtask

    task automatic wait_rvalid1(input string name);
        bit got;
        got = 0;
        for (int n = 0; n < 30; n++) begin
            tick;
            if (gnt_c[1]) req1 = 1'b0;
            if (rvalid_c[1]) begin
                got = 1;
                break;
            end
        end
        req1 = 1'b0;
        chk(name, got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick; tick;
        chk("rst_outputs", {gnt_c, err_c, rvalid_c, busy, ram_cs_0, ram_cs_1}, '0);
        rst = 1'b0;

        // 1: c0 writes 0xDEADBEEF to address 5
        req0 = 1'b1; we0 = 1'b1; a0 = 6'd5; wd0 = 32'hDEADBEEF;
        tick;
        chk("t1_gnt", gnt_c, 2'b01);
        chk("t1_setup", {ram_cs_0, ram_we_0, ram_address_0}, {1'b1, 1'b0, 6'd5});
        chk("t1_data", ram_data_0, 32'hDEADBEEF);
        req0 = 1'b0;
        tick;
        chk("t1_pulse", {ram_cs_0, ram_we_0}, 2'b11);
        tick;
        chk("t1_hold", {ram_cs_0, ram_we_0}, 2'b10);
        tick;
        chk("t1_idle", {ram_cs_0, ram_we_0, busy}, 3'b000);

        // 2: c1 reads address 5
        req1 = 1'b1; we1 = 1'b0; a1 = 6'd5;
        tick;
        chk("t2_gnt", gnt_c, 2'b10);
        chk("t2_setup", {ram_cs_1, ram_oe_1, ram_address_1}, {1'b1, 1'b1, 6'd5});
        req1 = 1'b0;
        tick;
        chk("t2_cap", {ram_cs_1, ram_oe_1, rvalid_c}, 4'b1100);
        tick;
        chk("t2_rvalid", {rvalid_c, ram_cs_1, ram_oe_1}, 4'b1000);
        chk("t2_rdata", rdata_c1, 32'hDEADBEEF);

        // 4: simultaneous c0 write @7 and c1 read @7 right after reset
        rst = 1'b1; tick; rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; a0 = 6'd7; wd0 = 32'h1;
        req1 = 1'b1; we1 = 1'b0; a1 = 6'd7;
        tick;
        chk("t4_first_gnt", gnt_c, 2'b01);
        req0 = 1'b0;
        wait_rvalid1("t4_rvalid_timeout");
        chk("t4_rdata", rdata_c1, 32'h1);

        // 3: both clients hold requests for 4 ops each
        rst = 1'b1; tick; rst = 1'b0;
        fork
            client_run(1'b0);
            client_run(1'b1);
        join
        tick; tick; tick;
        chk("t3_count", gq.size(), 8);
        for (int i = 0; i < gq.size(); i++) chk($sformatf("t3_order%0d", i), gq[i], i % 2);
        chk("t3_last_rdata", rdata_c1, 32'h1111_0003);

        // 5: out-of-range read from c1
        req1 = 1'b1; we1 = 1'b0; a1 = 6'd50;
        tick;
        chk("t5_gnt_err", {gnt_c, err_c}, 4'b1010);
        chk("t5_no_cs", {ram_cs_0, ram_cs_1, busy}, 3'b001);
        req1 = 1'b0;
        tick;
        chk("t5_after", {err_c, rvalid_c, busy, ram_cs_1}, 6'b0);

        // 6: reset during the write pulse
        req0 = 1'b1; we0 = 1'b1; a0 = 6'd9; wd0 = 32'hCAFEF00D;
        tick;
        req0 = 1'b0;
        tick;
        chk("t6_in_pulse", ram_we_0, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_strobes", {ram_we_0, ram_cs_0, busy, gnt_c}, 5'b0);
        chk("t6_rst_addr_data", {ram_address_0, ram_data_0, rdata_c1}, '0);
        tick;
        rst = 1'b0;
        req1 = 1'b1; we1 = 1'b0; a1 = 6'd5;
        wait_rvalid1("t6_rvalid_timeout");
        chk("t6_rdata", rdata_c1, 32'hDEADBEEF);

        tick; tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
